// File: rtl/rv32m_op_sequencer.sv
// RV32M sequencing unit: registered multiplier, restoring divider, early divide
// special cases and a one-entry result cache behind the start/busy/out contract.
module rv32m_op_sequencer #(
  parameter int DIV_ITERS  = 32,
  parameter int MUL_STAGES = 1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        rv32m_start,
  input  logic [2:0]  operation,
  input  logic [31:0] rv32m_a,
  input  logic [31:0] rv32m_b,
  output logic        rv32m_busy,
  output logic [31:0] rv32m_out
);

  localparam int CNT_W = $clog2(DIV_ITERS + MUL_STAGES + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               l_div_reg, l_div_next;
  logic               l_sa_reg, l_sa_next;
  logic               l_sb_reg, l_sb_next;
  logic [31:0]        l_a_reg, l_a_next;
  logic [31:0]        l_b_reg, l_b_next;
  logic [31:0]        dvd_reg, dvd_next;
  logic [31:0]        rem_reg, rem_next;

  // Cache entry: hi holds prod[63:32] or remainder, lo holds prod[31:0] or quotient
  logic               c_valid_reg, c_div_reg, c_sa_reg, c_sb_reg;
  logic [31:0]        c_a_reg, c_b_reg, c_hi_reg, c_lo_reg;
  logic               cache_we;
  logic [31:0]        wr_hi, wr_lo;

  logic               req_div, req_sa, req_sb, hit, same_req, sel_hi;
  logic [31:0]        a_abs, b_abs, rem_step, dvd_step, q_fix, r_fix;
  logic [32:0]        rem_sh;
  logic               ge;
  logic [63:0]        mul_prod, mul_tap;

  assign req_div = operation[2];
  assign req_sa  = req_div ? ~operation[0] : (operation == 3'd1 || operation == 3'd2);
  assign req_sb  = req_div ? ~operation[0] : (operation == 3'd1);

  // Low product bits do not depend on signedness, so plain MUL matches any MUL entry
  assign hit = rv32m_start & c_valid_reg & (c_div_reg == req_div) &
               (rv32m_a == c_a_reg) & (rv32m_b == c_b_reg) &
               (((req_sa == c_sa_reg) & (req_sb == c_sb_reg)) | (operation == 3'd0));

  assign same_req = (l_div_reg == req_div) & (l_sa_reg == req_sa) & (l_sb_reg == req_sb) &
                    (l_a_reg == rv32m_a) & (l_b_reg == rv32m_b);

  assign sel_hi     = (operation inside {3'd1, 3'd2, 3'd3, 3'd6, 3'd7});
  assign rv32m_busy = rv32m_start & ~hit;
  assign rv32m_out  = hit ? (sel_hi ? c_hi_reg : c_lo_reg) : 32'd0;

  // Low 64 bits of the 64x64 product of extended operands equal the 33x33 product
  assign mul_prod = {{32{l_sa_reg & l_a_reg[31]}}, l_a_reg} *
                    {{32{l_sb_reg & l_b_reg[31]}}, l_b_reg};

  generate
    if (MUL_STAGES > 1) begin : g_pipe
      logic [63:0] pipe_reg [MUL_STAGES-1];
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          for (int i = 0; i < MUL_STAGES - 1; i++) pipe_reg[i] <= '0;
        end else begin
          pipe_reg[0] <= mul_prod;
          for (int i = 1; i < MUL_STAGES - 1; i++) pipe_reg[i] <= pipe_reg[i-1];
        end
      end
      assign mul_tap = pipe_reg[MUL_STAGES-2];
    end else begin : g_nopipe
      assign mul_tap = mul_prod;
    end
  endgenerate

  assign a_abs    = (req_sa & rv32m_a[31]) ? -rv32m_a : rv32m_a;
  assign b_abs    = (l_sb_reg & l_b_reg[31]) ? -l_b_reg : l_b_reg;
  assign rem_sh   = {rem_reg, dvd_reg[31]};
  assign ge       = rem_sh >= {1'b0, b_abs};
  assign rem_step = ge ? (rem_sh[31:0] - b_abs) : rem_sh[31:0];
  assign dvd_step = {dvd_reg[30:0], ge};
  assign q_fix    = (l_sa_reg & (l_a_reg[31] ^ l_b_reg[31])) ? -dvd_step : dvd_step;
  assign r_fix    = (l_sa_reg & l_a_reg[31]) ? -rem_step : rem_step;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    l_div_next = l_div_reg;
    l_sa_next  = l_sa_reg;
    l_sb_next  = l_sb_reg;
    l_a_next   = l_a_reg;
    l_b_next   = l_b_reg;
    dvd_next   = dvd_reg;
    rem_next   = rem_reg;
    cache_we   = 1'b0;
    wr_hi      = 32'd0;
    wr_lo      = 32'd0;
    case (state_reg)
      IDLE: begin
        if (rv32m_start && !hit) begin
          l_div_next = req_div;
          l_sa_next  = req_sa;
          l_sb_next  = req_sb;
          l_a_next   = rv32m_a;
          l_b_next   = rv32m_b;
          if (!req_div) begin
            state_next = MUL;
            cnt_next   = CNT_W'(MUL_STAGES);
          end else if (rv32m_b == 32'd0) begin
            cache_we = 1'b1;
            wr_hi    = rv32m_a;
            wr_lo    = 32'hFFFF_FFFF;
          end else if (req_sa && rv32m_a == 32'h8000_0000 && rv32m_b == 32'hFFFF_FFFF) begin
            cache_we = 1'b1;
            wr_hi    = 32'd0;
            wr_lo    = rv32m_a;
          end else begin
            state_next = DIV;
            cnt_next   = CNT_W'(DIV_ITERS);
            dvd_next   = a_abs;
            rem_next   = 32'd0;
          end
        end
      end
      MUL: begin
        if (!rv32m_start || !same_req) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
          if (cnt_reg == CNT_W'(1)) begin
            cache_we   = 1'b1;
            wr_hi      = mul_tap[63:32];
            wr_lo      = mul_tap[31:0];
            state_next = IDLE;
          end
        end
      end
      DIV: begin
        if (!rv32m_start || !same_req) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
          dvd_next = dvd_step;
          rem_next = rem_step;
          if (cnt_reg == CNT_W'(1)) begin
            cache_we   = 1'b1;
            wr_hi      = r_fix;
            wr_lo      = q_fix;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      l_div_reg   <= 1'b0;
      l_sa_reg    <= 1'b0;
      l_sb_reg    <= 1'b0;
      l_a_reg     <= 32'd0;
      l_b_reg     <= 32'd0;
      dvd_reg     <= 32'd0;
      rem_reg     <= 32'd0;
      c_valid_reg <= 1'b0;
      c_div_reg   <= 1'b0;
      c_sa_reg    <= 1'b0;
      c_sb_reg    <= 1'b0;
      c_a_reg     <= 32'd0;
      c_b_reg     <= 32'd0;
      c_hi_reg    <= 32'd0;
      c_lo_reg    <= 32'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      l_div_reg <= l_div_next;
      l_sa_reg  <= l_sa_next;
      l_sb_reg  <= l_sb_next;
      l_a_reg   <= l_a_next;
      l_b_reg   <= l_b_next;
      dvd_reg   <= dvd_next;
      rem_reg   <= rem_next;
      // Writes only happen while the live request matches, so tag it from the inputs
      if (cache_we) begin
        c_valid_reg <= 1'b1;
        c_div_reg   <= req_div;
        c_sa_reg    <= req_sa;
        c_sb_reg    <= req_sb;
        c_a_reg     <= rv32m_a;
        c_b_reg     <= rv32m_b;
        c_hi_reg    <= wr_hi;
        c_lo_reg    <= wr_lo;
      end
    end
  end

endmodule

// File: tb/tb_rv32m_op_sequencer.sv
// Scoreboard bench for rv32m_op_sequencer: the driver queues expected result and
// stall length per instruction, the monitor retires them when busy drops.
module tb_rv32m_op_sequencer;

  localparam int DIV_ITERS  = 32;
  localparam int MUL_STAGES = 1;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        rv32m_start;
  logic [2:0]  operation;
  logic [31:0] rv32m_a, rv32m_b;
  logic        rv32m_busy;
  logic [31:0] rv32m_out;

  always #5 CLK = ~CLK;

  rv32m_op_sequencer #(.DIV_ITERS(DIV_ITERS), .MUL_STAGES(MUL_STAGES)) dut (
    .CLK(CLK), .nRST(nRST), .rv32m_start(rv32m_start), .operation(operation),
    .rv32m_a(rv32m_a), .rv32m_b(rv32m_b), .rv32m_busy(rv32m_busy), .rv32m_out(rv32m_out)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] out;
    int          stall;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   stall  = 0;

  // Reference: which request last completed through the unit
  bit          m_valid = 0;
  bit          m_div, m_sa, m_sb;
  logic [31:0] m_a, m_b;

  function automatic bit sgn_a(input logic [2:0] op);
    return op[2] ? ~op[0] : (op == 3'd1 || op == 3'd2);
  endfunction

  function automatic bit sgn_b(input logic [2:0] op);
    return op[2] ? ~op[0] : (op == 3'd1);
  endfunction

  function automatic logic [63:0] ext(input logic [31:0] v, input bit s);
    return s ? {{32{v[31]}}, v} : {32'd0, v};
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    bool_ovf: begin end
    p = ext(a, sgn_a(op)) * ext(b, sgn_b(op));
    case (op)
      3'd0: return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit model_hit(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!m_valid || m_div != op[2] || m_a != a || m_b != b) return 0;
    if (op == 3'd0) return 1;
    return (m_sa == sgn_a(op)) && (m_sb == sgn_b(op));
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && (b == 0 || (sgn_a(op) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic bit normal_miss(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return !model_hit(op, a, b) && !is_special(op, a, b);
  endfunction

  task automatic finish_tb();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // extra: cycles spent unwinding an operation that was still in flight
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int extra);
    exp_t e;
    bit   done = 0;
    e.op = op; e.a = a; e.b = b;
    e.out = ref_result(op, a, b);
    if (model_hit(op, a, b)) e.stall = 0;
    else begin
      if (is_special(op, a, b)) e.stall = 1 + extra;
      else if (op[2])           e.stall = 1 + DIV_ITERS + extra;
      else                      e.stall = 1 + MUL_STAGES + extra;
      m_valid = 1; m_div = op[2]; m_sa = sgn_a(op); m_sb = sgn_b(op); m_a = a; m_b = b;
    end
    sb_q.push_back(e);
    rv32m_start = 1'b1; operation = op; rv32m_a = a; rv32m_b = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (!rv32m_busy) begin done = 1; break; end
    end
    if (!done) begin
      errors++; checks++;
      $display("FAIL issue_timeout op=%0d a=%h b=%h busy still %0b, required 0", op, a, b, rv32m_busy);
      finish_tb();
    end
    step();
  endtask

  task automatic idle(input int n);
    rv32m_start = 1'b0;
    repeat (n) step();
  endtask

  task automatic drive_partial(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int k);
    rv32m_start = 1'b1; operation = op; rv32m_a = a; rv32m_b = b;
    repeat (k) begin
      @(negedge CLK);
      checks++;
      if (rv32m_busy !== 1'b1) begin
        errors++;
        $display("FAIL partial_busy op=%0d a=%h b=%h busy=%0b required 1", op, a, b, rv32m_busy);
      end
      step();
    end
  endtask

  task automatic pulse_reset();
    nRST = 1'b0;
    m_valid = 0;
    repeat (2) step();
    nRST = 1'b1;
  endtask

  // Monitor: stall run restarts whenever the request changes, drops or reset holds
  logic [67:0] prev_req = '0;
  always @(negedge CLK) begin
    exp_t e;
    if (!nRST || !rv32m_start || {operation, rv32m_a, rv32m_b} != prev_req) stall = 0;
    prev_req = {operation, rv32m_a, rv32m_b};
    if (!rv32m_start) begin
      checks++;
      if (rv32m_busy !== 1'b0 || rv32m_out !== 32'd0) begin
        errors++;
        $display("FAIL idle_outputs busy=%0b out=%h required busy=0 out=0", rv32m_busy, rv32m_out);
      end
    end else if (!nRST) begin
      checks++;
      if (rv32m_busy !== 1'b1 || rv32m_out !== 32'd0) begin
        errors++;
        $display("FAIL reset_busy busy=%0b out=%h required busy=1 out=0", rv32m_busy, rv32m_out);
      end
    end else if (rv32m_busy) begin
      stall++;
      checks++;
      if (rv32m_out !== 32'd0) begin
        errors++;
        $display("FAIL busy_out out=%h required 0", rv32m_out);
      end
    end else begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_completion op=%0d out=%h required no completion", operation, rv32m_out);
      end else begin
        e = sb_q.pop_front();
        checks += 2;
        $display("txn op=%0d a=%h b=%h out=%h exp=%h stall=%0d exp_stall=%0d",
                 e.op, e.a, e.b, rv32m_out, e.out, stall, e.stall);
        if (rv32m_out !== e.out) begin
          errors++;
          $display("FAIL result op=%0d a=%h b=%h got %h required %h", e.op, e.a, e.b, rv32m_out, e.out);
        end
        if (stall != e.stall) begin
          errors++;
          $display("FAIL stall op=%0d a=%h b=%h got %0d cycles required %0d", e.op, e.a, e.b, stall, e.stall);
        end
      end
      stall = 0;
    end
  end

  initial begin
    #1_000_000;
    errors++; checks++;
    $display("FAIL watchdog simulation did not complete, required completion");
    finish_tb();
  end

  logic [31:0] pool [8] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFD,
                            32'h8000_0000, 32'd6, 32'hFFFF_FFEC};

  function automatic logic [31:0] pick();
    return ($urandom_range(3) != 0) ? pool[$urandom_range(7)] : $urandom();
  endfunction

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    int          act, k;

    nRST = 1'b0; rv32m_start = 1'b0; operation = 3'd0; rv32m_a = 0; rv32m_b = 0;
    repeat (2) step();
    rv32m_start = 1'b1; operation = 3'd4; rv32m_a = 32'd5; rv32m_b = 32'd1;
    step();
    rv32m_start = 1'b0;
    step();
    nRST = 1'b1;
    step();

    // Multiply family, hit rules between MUL/MULHU/MULH
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    issue(3'd3, 32'd7, 32'hFFFF_FFFD, 0);
    issue(3'd1, 32'd7, 32'hFFFF_FFFD, 0);
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    // Divide and paired remainder
    issue(3'd4, 32'hFFFF_FFEC, 32'd6, 0);
    issue(3'd6, 32'hFFFF_FFEC, 32'd6, 0);
    // Early special cases
    issue(3'd5, 32'd100, 32'd0, 0);
    issue(3'd7, 32'd100, 32'd0, 0);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    idle(1);
    // Start dropped mid-divide; prior entry survives, re-request starts over
    drive_partial(3'd4, 32'd1000, 32'd7, 10);
    idle(1);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    issue(3'd4, 32'd1000, 32'd7, 0);
    // Divisor changes while start stays high
    drive_partial(3'd4, 32'd12345, 32'd6, 5);
    issue(3'd4, 32'd12345, 32'd7, 1);
    // Reset invalidates the cache
    idle(1);
    pulse_reset();
    step();
    issue(3'd4, 32'd12345, 32'd7, 0);
    // Reset in the middle of a multiply with start held
    drive_partial(3'd1, 32'd5, 32'd9, 1);
    pulse_reset();
    issue(3'd1, 32'd5, 32'd9, 0);
    issue(3'd4, 32'd12345, 32'd7, 0);

    for (int n = 0; n < 300; n++) begin
      op = 3'($urandom_range(7)); a = pick(); b = pick();
      act = $urandom_range(9);
      if (act == 0) begin
        idle($urandom_range(1, 3));
        issue(op, a, b, 0);
      end else if (act == 1 && normal_miss(op, a, b)) begin
        drive_partial(op, a, b, $urandom_range(1, op[2] ? DIV_ITERS : MUL_STAGES));
        idle($urandom_range(1, 2));
      end else if (act == 2 && normal_miss(op, a, b)) begin
        k = $urandom_range(1, op[2] ? DIV_ITERS : MUL_STAGES);
        drive_partial(op, a, b, k);
        issue(op, a, b + 32'd1, 1);
      end else begin
        issue(op, a, b, 0);
      end
    end

    idle(3);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d required 0", sb_q.size());
    end
    finish_tb();
  end

endmodule
